// File: rtl/mem_issue_scheduler_if.sv
// Memory micro-op bus: one valid/ready handshake plus the op fields.
// It is used twice on the scheduler. The dispatch side is the slave and the issue side is the master.
//   valid      : op offered this cycle
//   ready      : receiver accepts the op
//   opcode     : opcode[0]=1 store, 0 load
//   rob_entry  : ROB tag
//   base_val   : base address
//   offset     : unsigned address offset
//   dest_reg   : load destination physical register
//   data       : store data
//   imm        : imm[3]=1 selects zero-page/page-wrap addressing
//   dest_arch  : destination arch-register mask
interface mem_issue_scheduler_if #(
  parameter int PR_ADDR_W = 6
);
  logic                 valid;
  logic                 ready;
  logic [3:0]           opcode;
  logic [4:0]           rob_entry;
  logic [15:0]          base_val;
  logic [7:0]           offset;
  logic [PR_ADDR_W-1:0] dest_reg;
  logic [7:0]           data;
  logic [3:0]           imm;
  logic [3:0]           dest_arch;

  modport master (
    output valid, opcode, rob_entry, base_val, offset, dest_reg, data, imm, dest_arch,
    input  ready
  );

  modport slave (
    input  valid, opcode, rob_entry, base_val, offset, dest_reg, data, imm, dest_arch,
    output ready
  );
endinterface

// File: rtl/mem_issue_scheduler.sv
// mem_issue_scheduler
// Buffers dispatched loads and stores in an age-ordered queue. Slot 0 always holds the oldest op.
// The scheduler issues at most one op per cycle into the memory pipeline.
// A store issues only from slot 0, and only in the cycle the ROB commits its tag.
// A load may bypass older stores, but only when no older store targets the same effective address.
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset
//   in_bus         : dispatch side (slave); ready = queue not full, based on the registered count
//   out_bus        : issue side (master); combinational from the queue, fields passed unmodified
//   commit_valid   : ROB head is retiring this cycle
//   commit_entry   : ROB tag at the head
//   flush          : squash every queued op and drop any enqueue in the same cycle
//   count          : number of valid entries
module mem_issue_scheduler #(
  parameter int DEPTH     = 4,
  parameter int PR_ADDR_W = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  mem_issue_scheduler_if.slave       in_bus,
  mem_issue_scheduler_if.master      out_bus,
  input  logic                       commit_valid,
  input  logic [4:0]                 commit_entry,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic [3:0]           opcode;
    logic [4:0]           rob_entry;
    logic [15:0]          base_val;
    logic [7:0]           offset;
    logic [PR_ADDR_W-1:0] dest_reg;
    logic [7:0]           data;
    logic [3:0]           imm;
    logic [3:0]           dest_arch;
    logic [15:0]          ea;
  } entry_t;

  entry_t           q [DEPTH];
  entry_t           new_entry;
  logic [DEPTH-1:0] elig;
  logic [IDX_W-1:0] pick;
  logic             issue_valid;
  logic             deq;
  logic             enq;
  logic             in_ready;
  logic [CNT_W-1:0] wr_idx;

  // Zero-page mode keeps the page byte and wraps only the low byte.
  function automatic logic [15:0] calc_ea(input logic [15:0] base, input logic [7:0] offset,
                                          input logic zero_page);
    logic [7:0] lo;
    lo = base[7:0] + offset;
    if (zero_page) return {base[15:8], lo};
    return base + {8'h00, offset};
  endfunction

  always_comb begin
    new_entry.opcode    = in_bus.opcode;
    new_entry.rob_entry = in_bus.rob_entry;
    new_entry.base_val  = in_bus.base_val;
    new_entry.offset    = in_bus.offset;
    new_entry.dest_reg  = in_bus.dest_reg;
    new_entry.data      = in_bus.data;
    new_entry.imm       = in_bus.imm;
    new_entry.dest_arch = in_bus.dest_arch;
    new_entry.ea        = calc_ea(in_bus.base_val, in_bus.offset, in_bus.imm[3]);
  end

  // Eligibility is evaluated on the registered queue only.
  // An entry enqueued this cycle therefore cannot issue until the next cycle.
  always_comb begin
    logic blocked;
    elig    = '0;
    blocked = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < count) begin
        if (q[i].opcode[0]) begin
          elig[i] = (i == 0) && commit_valid && (commit_entry == q[0].rob_entry);
        end else begin
          blocked = 1'b0;
          for (int j = 0; j < i; j++) begin
            if (q[j].opcode[0] && (q[j].ea == q[i].ea)) blocked = 1'b1;
          end
          elig[i] = !blocked;
        end
      end
    end
  end

  always_comb begin
    pick = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (elig[i]) pick = IDX_W'(i);
    end
  end

  // Issue is suppressed while reset is asserted.
  // This guarantees that no op leaves in the same cycle the queue is discarded.
  assign issue_valid       = rst_n && !flush && (|elig);
  assign deq               = issue_valid && out_bus.ready;
  assign in_ready          = (count != CNT_W'(DEPTH));
  assign enq               = in_bus.valid && in_ready && !flush;
  assign wr_idx            = count - CNT_W'(deq);
  assign in_bus.ready      = in_ready;

  assign out_bus.valid     = issue_valid;
  assign out_bus.opcode    = q[pick].opcode;
  assign out_bus.rob_entry = q[pick].rob_entry;
  assign out_bus.base_val  = q[pick].base_val;
  assign out_bus.offset    = q[pick].offset;
  assign out_bus.dest_reg  = q[pick].dest_reg;
  assign out_bus.data      = q[pick].data;
  assign out_bus.imm       = q[pick].imm;
  assign out_bus.dest_arch = q[pick].dest_arch;

  // Queue storage boundary.
  // Younger entries collapse over the issued slot.
  // An enqueue lands just past the surviving entries and overrides any shift into the same slot.
  always_ff @(posedge clk) begin
    if (deq) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (IDX_W'(i) >= pick) q[i] <= q[i+1];
      end
    end
    if (enq) q[wr_idx[IDX_W-1:0]] <= new_entry;
  end

  // Occupancy boundary: the count alone defines which slots are valid.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) count <= '0;
    else                 count <= count + CNT_W'(enq) - CNT_W'(deq);
  end
endmodule

// File: tb/tb_mem_issue_scheduler.sv
module tb_mem_issue_scheduler;
  localparam int DEPTH     = 4;
  localparam int PR_ADDR_W = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       commit_valid = 1'b0;
  logic [4:0] commit_entry = '0;
  logic       flush = 1'b0;
  logic [2:0] count;

  always #5 clk = ~clk;

  mem_issue_scheduler_if #(.PR_ADDR_W(PR_ADDR_W)) in_bus ();
  mem_issue_scheduler_if #(.PR_ADDR_W(PR_ADDR_W)) out_bus ();

  mem_issue_scheduler #(.DEPTH(DEPTH), .PR_ADDR_W(PR_ADDR_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_bus       (in_bus),
    .out_bus      (out_bus),
    .commit_valid (commit_valid),
    .commit_entry (commit_entry),
    .flush        (flush),
    .count        (count)
  );

  typedef struct packed {
    logic [3:0]  opc;
    logic [4:0]  rob;
    logic [15:0] base;
    logic [7:0]  off;
    logic [5:0]  dest;
    logic [7:0]  data;
    logic [3:0]  imm;
    logic [3:0]  arch;
  } op_t;

  op_t mq[$];     // reference queue, oldest first
  op_t exp_q[$];  // scoreboard of expected issues
  op_t mon_e;
  int  errors = 0;
  int  checks = 0;
  logic [15:0] bases [4];
  logic [7:0]  offs  [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [15:0] ref_ea(input op_t o);
    logic [7:0] lo;
    lo = o.base[7:0] + o.off;
    if (o.imm[3]) return {o.base[15:8], lo};
    return o.base + {8'h00, o.off};
  endfunction

  // The oldest op the issue rules allow, or -1 if none qualifies.
  function automatic int model_pick(input logic cv, input logic [4:0] ce);
    for (int k = 0; k < mq.size(); k++) begin
      if (mq[k].opc[0]) begin
        if (k == 0 && cv && ce == mq[0].rob) return k;
      end else begin
        bit hit = 0;
        for (int j = 0; j < k; j++)
          if (mq[j].opc[0] && ref_ea(mq[j]) == ref_ea(mq[k])) hit = 1;
        if (!hit) return k;
      end
    end
    return -1;
  endfunction

  function automatic op_t mk(input bit st, input logic [4:0] rob, input logic [15:0] base,
                             input logic [7:0] off, input logic [3:0] imm);
    op_t o;
    o.opc  = {3'($urandom), st};
    o.rob  = rob;
    o.base = base;
    o.off  = off;
    o.dest = 6'($urandom);
    o.data = 8'($urandom);
    o.imm  = imm;
    o.arch = 4'($urandom);
    return o;
  endfunction

  task automatic cycle(input logic iv, input op_t op, input logic cv, input logic [4:0] ce,
                       input logic fl, input logic ordy);
    int  p;
    bit  deq, enq;
    in_bus.valid     = iv;
    in_bus.opcode    = op.opc;
    in_bus.rob_entry = op.rob;
    in_bus.base_val  = op.base;
    in_bus.offset    = op.off;
    in_bus.dest_reg  = op.dest;
    in_bus.data      = op.data;
    in_bus.imm       = op.imm;
    in_bus.dest_arch = op.arch;
    commit_valid     = cv;
    commit_entry     = ce;
    flush            = fl;
    out_bus.ready    = ordy;
    #1;
    p = (fl || !rst_n) ? -1 : model_pick(cv, ce);
    check("out_valid", 32'(out_bus.valid), 32'(p >= 0));
    if (rst_n) begin
      check("in_ready", 32'(in_bus.ready), 32'(mq.size() != DEPTH));
      check("count", 32'(count), 32'(mq.size()));
    end
    deq = (p >= 0) && ordy;
    enq = iv && (mq.size() != DEPTH) && !fl;
    if (deq) exp_q.push_back(mq[p]);
    @(posedge clk);
    if (!rst_n || fl) mq.delete();
    else begin
      if (deq) mq.delete(p);
      if (enq) mq.push_back(op);
    end
    #1;
    check("issue_seen", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Monitor: every accepted issue must match the oldest expected issue.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_bus.valid === 1'b1 && out_bus.ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue actual rob=%0h required no issue at %0t",
                 out_bus.rob_entry, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("iss_rob",  32'(out_bus.rob_entry), 32'(mon_e.rob));
        check("iss_opc",  32'(out_bus.opcode),    32'(mon_e.opc));
        check("iss_base", 32'(out_bus.base_val),  32'(mon_e.base));
        check("iss_off",  32'(out_bus.offset),    32'(mon_e.off));
        check("iss_dest", 32'(out_bus.dest_reg),  32'(mon_e.dest));
        check("iss_data", 32'(out_bus.data),      32'(mon_e.data));
        check("iss_imm",  32'(out_bus.imm),       32'(mon_e.imm));
        check("iss_arch", 32'(out_bus.dest_arch), 32'(mon_e.arch));
      end
    end
  end

  initial begin
    op_t z, o;
    logic iv, cv, fl, ordy;
    logic [4:0] ce;
    z = '0;
    bases[0] = 16'h1200; bases[1] = 16'h12F0; bases[2] = 16'h1300; bases[3] = 16'h1310;
    offs[0] = 8'h00; offs[1] = 8'h10; offs[2] = 8'h20; offs[3] = 8'h0F; offs[4] = 8'hFF;
    out_bus.ready = 1'b1;
    in_bus.valid  = 1'b0;
    #1;

    // Reset for two cycles.
    rst_n = 1'b0;
    cycle(0, z, 0, 0, 0, 1);
    cycle(0, z, 0, 0, 0, 1);
    rst_n = 1'b1;
    cycle(0, z, 0, 0, 0, 1);

    // A load bypasses an older store; the store waits for its commit.
    cycle(1, mk(1, 5'd3, 16'h1200, 8'h34, 4'h0), 0, 0, 0, 1);
    cycle(1, mk(0, 5'd4, 16'h2000, 8'h10, 4'h0), 0, 0, 0, 1);
    repeat (3) cycle(0, z, 0, 0, 0, 1);
    cycle(0, z, 1, 5'd3, 0, 1);
    cycle(0, z, 0, 0, 0, 1);

    // A load to the same EA as an older store is blocked until that store issues.
    cycle(1, mk(1, 5'd5, 16'h12F0, 8'h0F, 4'h0), 0, 0, 0, 1);
    cycle(1, mk(0, 5'd6, 16'h1200, 8'hFF, 4'h0), 0, 0, 0, 1);
    repeat (2) cycle(0, z, 0, 0, 0, 1);
    cycle(0, z, 1, 5'd5, 0, 1);
    repeat (2) cycle(0, z, 0, 0, 0, 1);

    // Page-wrap EA avoids the conflict; the linear EA of the same load collides.
    cycle(1, mk(1, 5'd7, 16'h1300, 8'h10, 4'h0), 0, 0, 0, 1);
    cycle(1, mk(0, 5'd8, 16'h12F0, 8'h20, 4'h8), 0, 0, 0, 1);
    repeat (2) cycle(0, z, 0, 0, 0, 1);
    cycle(1, mk(0, 5'd9, 16'h12F0, 8'h20, 4'h0), 0, 0, 0, 1);
    repeat (2) cycle(0, z, 0, 0, 0, 1);
    cycle(0, z, 1, 5'd7, 0, 1);
    repeat (2) cycle(0, z, 0, 0, 0, 1);

    // Full queue: a fifth op is held until space opens, then ops drain in order.
    for (int i = 1; i <= 4; i++) cycle(1, mk(0, 5'(i), 16'h4000, 8'(i), 4'h0), 0, 0, 0, 0);
    o = mk(0, 5'd10, 16'h5000, 8'h00, 4'h0);
    repeat (2) cycle(1, o, 0, 0, 0, 0);
    repeat (3) cycle(1, o, 0, 0, 0, 1);
    repeat (4) cycle(0, z, 0, 0, 0, 1);

    // Flush with a concurrent enqueue.
    for (int i = 0; i < 3; i++) cycle(1, mk(0, 5'(11 + i), 16'h6000, 8'(i), 4'h0), 0, 0, 0, 0);
    cycle(1, mk(0, 5'd20, 16'h7000, 8'h00, 4'h0), 0, 0, 1, 1);
    repeat (2) cycle(0, z, 0, 0, 0, 1);

    // Randomized traffic with a narrow address space so EA collisions occur often.
    for (int n = 0; n < 3000; n++) begin
      iv   = ($urandom_range(0, 3) != 0);
      o    = mk(1'($urandom), 5'($urandom), bases[$urandom_range(0, 3)],
                offs[$urandom_range(0, 4)], {1'($urandom), 3'($urandom)});
      fl   = ($urandom_range(0, 40) == 0);
      ordy = ($urandom_range(0, 4) != 0);
      if (mq.size() > 0 && mq[0].opc[0] && $urandom_range(0, 2) == 0) begin
        cv = 1'b1;
        ce = mq[0].rob;
      end else begin
        cv = ($urandom_range(0, 7) == 0);
        ce = 5'($urandom);
      end
      if (fl) cv = 1'b0;
      rst_n = ($urandom_range(0, 200) != 0);
      cycle(iv, o, cv, ce, fl, ordy);
      rst_n = 1'b1;
    end
    repeat (3) cycle(0, z, 0, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
